// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code set 2 constants, event record and parser states
package kbd_pkg;

    localparam int EVT_W = 22;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_FA     = 8'hFA;
    localparam logic [7:0] SC_EE     = 8'hEE;
    localparam logic [7:0] SC_FE     = 8'hFE;
    localparam logic [7:0] SC_SHIFTL = 8'h12;
    localparam logic [7:0] SC_SHIFTR = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_GUIL   = 8'h1F;
    localparam logic [7:0] SC_GUIR   = 8'h27;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_NUM    = 8'h77;
    localparam logic [7:0] SC_SCROLL = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    typedef struct packed {
        logic       rpt;
        logic       rel;
        logic       ext;
        logic [7:0] code;
        logic [7:0] mods;
        logic [2:0] locks;
    } evt_t;

    // Keyboard housekeeping responses that never denote a key in the idle state.
    function automatic logic is_dropped(input logic [7:0] c);
        return (c == SC_FA) || (c == SC_EE) || (c == SC_FE) ||
               (c == 8'h00) || (c == 8'hFF);
    endfunction

    // Bit order {rgui,lgui,ralt,lalt,rctrl,lctrl,rshift,lshift}.
    function automatic logic [7:0] mod_onehot(input logic ext, input logic [7:0] c);
        logic [7:0] m;
        m = 8'h00;
        if (!ext && c == SC_SHIFTL) m = 8'h01;
        if (!ext && c == SC_SHIFTR) m = 8'h02;
        if (!ext && c == SC_CTRL)   m = 8'h04;
        if ( ext && c == SC_CTRL)   m = 8'h08;
        if (!ext && c == SC_ALT)    m = 8'h10;
        if ( ext && c == SC_ALT)    m = 8'h20;
        if ( ext && c == SC_GUIL)   m = 8'h40;
        if ( ext && c == SC_GUIR)   m = 8'h80;
        return m;
    endfunction

    // Bit order {scroll,num,caps}.
    function automatic logic [2:0] lock_onehot(input logic [7:0] c);
        logic [2:0] l;
        l = 3'b000;
        if (c == SC_CAPS)   l = 3'b001;
        if (c == SC_NUM)    l = 3'b010;
        if (c == SC_SCROLL) l = 3'b100;
        return l;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - synchronous show-ahead event FIFO
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 22
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_rd;
    logic          w_wr;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - set-2 scan-code parser, key state tracking and event queue
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter bit REPEAT_EN = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic              mainclk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [7:0]        code,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [EVT_W-1:0]  evt_data,
    output logic [7:0]        mods,
    output logic [2:0]        locks,
    output logic              led_update,
    output logic [9:0]        pressed_cnt,
    output logic [CNT_W-1:0]  new_press_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    parse_state_t     r_state;
    logic [511:0]     r_bitmap;
    logic [7:0]       r_mods;
    logic [2:0]       r_locks;
    logic             r_led_update;
    logic [9:0]       r_pressed_cnt;
    logic [CNT_W-1:0] r_new_press_cnt;
    logic             r_overflow;

    logic             w_key_fire;
    logic             w_key_ext;
    logic             w_key_rel;
    logic             w_bat;
    logic [8:0]       w_idx;
    logic             w_held;
    logic             w_new_make;
    logic             w_rpt;
    logic             w_brk;
    logic [7:0]       w_mod_bit;
    logic [7:0]       w_mods_next;
    logic [2:0]       w_lock_bit;
    logic [2:0]       w_locks_next;
    logic             w_push_req;
    logic             w_push_ok;
    logic             w_pop;
    evt_t             w_evt;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;

    always_comb begin
        w_key_fire = 1'b0;
        w_key_ext  = 1'b0;
        w_key_rel  = 1'b0;
        w_bat      = 1'b0;
        if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code == SC_AA) begin
                        w_bat = 1'b1;
                    end else if (code != SC_E0 && code != SC_F0 && !is_dropped(code)) begin
                        w_key_fire = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_key_fire = (code != SC_E0) && (code != SC_F0);
                    w_key_ext  = 1'b1;
                end
                ST_BRK: begin
                    w_key_fire = (code != SC_E0) && (code != SC_F0);
                    w_key_rel  = 1'b1;
                end
                default: begin
                    w_key_fire = (code != SC_E0) && (code != SC_F0);
                    w_key_ext  = 1'b1;
                    w_key_rel  = 1'b1;
                end
            endcase
        end
    end

    assign w_idx      = {w_key_ext, code};
    assign w_held     = r_bitmap[w_idx];
    assign w_new_make = w_key_fire & ~w_key_rel & ~w_held;
    assign w_rpt      = w_key_fire & ~w_key_rel &  w_held;
    assign w_brk      = w_key_fire &  w_key_rel &  w_held;

    // Modifiers only change on state transitions, so they always mirror the bitmap.
    assign w_mod_bit    = mod_onehot(w_key_ext, code);
    assign w_mods_next  = w_new_make ? (r_mods | w_mod_bit) :
                          w_brk      ? (r_mods & ~w_mod_bit) : r_mods;
    assign w_lock_bit   = (w_new_make && !w_key_ext) ? lock_onehot(code) : 3'b000;
    assign w_locks_next = r_locks ^ w_lock_bit;

    assign w_push_req = w_new_make | w_brk | (w_rpt & REPEAT_EN);
    assign w_pop      = ~w_empty & evt_ready;
    assign w_push_ok  = (w_count < FULL_CNT) | (w_full & w_pop);

    always_comb begin
        w_evt.rpt   = w_rpt;
        w_evt.rel   = w_key_rel;
        w_evt.ext   = w_key_ext;
        w_evt.code  = code;
        w_evt.mods  = w_mods_next;
        w_evt.locks = w_locks_next;
    end

    always_ff @(posedge mainclk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_bitmap        <= '0;
            r_mods          <= '0;
            r_locks         <= '0;
            r_led_update    <= 1'b0;
            r_pressed_cnt   <= '0;
            r_new_press_cnt <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_led_update <= |w_lock_bit;
            r_overflow   <= (w_push_req & ~w_push_ok) | (r_overflow & ~clr_ovf);

            if (code_valid) begin
                case (r_state)
                    ST_IDLE: r_state <= (code == SC_E0) ? ST_EXT :
                                        (code == SC_F0) ? ST_BRK : ST_IDLE;
                    ST_EXT:  r_state <= (code == SC_E0) ? ST_EXT :
                                        (code == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end

            // Self-test completion: keyboard has forgotten its held keys, locks survive.
            if (w_bat) begin
                r_bitmap      <= '0;
                r_mods        <= '0;
                r_pressed_cnt <= '0;
            end else begin
                if (w_new_make) begin
                    r_bitmap[w_idx] <= 1'b1;
                    r_pressed_cnt   <= r_pressed_cnt + 10'd1;
                    r_new_press_cnt <= r_new_press_cnt + CNT_W'(1);
                end
                if (w_brk) begin
                    r_bitmap[w_idx] <= 1'b0;
                    r_pressed_cnt   <= r_pressed_cnt - 10'd1;
                end
                r_mods  <= w_mods_next;
                r_locks <= w_locks_next;
            end
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .i_clk   (mainclk),
        .i_reset (reset),
        .i_push  (w_push_req & w_push_ok),
        .i_wdata (w_evt),
        .i_pop   (w_pop),
        .o_rdata (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign evt_valid     = ~w_empty;
    assign mods          = r_mods;
    assign locks         = r_locks;
    assign led_update    = r_led_update;
    assign pressed_cnt   = r_pressed_cnt;
    assign new_press_cnt = r_new_press_cnt;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb/tb_kbd_event_ctrl.sv - directed vector bench for kbd_event_ctrl
module tb_kbd_event_ctrl;
    localparam int DEPTH = 8;

    logic        mainclk = 1'b0;
    logic        reset = 1'b1;
    logic        code_valid = 1'b0;
    logic [7:0]  code = 8'h00;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [21:0] evt_data;
    logic [7:0]  mods;
    logic [2:0]  locks;
    logic        led_update;
    logic [9:0]  pressed_cnt;
    logic [7:0]  new_press_cnt;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int checks = 0;
    int failures = 0;
    int led_cnt = 0;
    bit mon_en = 1'b0;

    kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_EN(1'b1), .CNT_W(8)) dut (
        .mainclk       (mainclk),
        .reset         (reset),
        .code_valid    (code_valid),
        .code          (code),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_data      (evt_data),
        .mods          (mods),
        .locks         (locks),
        .led_update    (led_update),
        .pressed_cnt   (pressed_cnt),
        .new_press_cnt (new_press_cnt),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf)
    );

    always #5 mainclk = ~mainclk;

    always @(negedge mainclk) begin
        if (mon_en && led_update) led_cnt++;
    end

    typedef struct {
        logic [7:0]  b;
        logic        ev;
        logic [21:0] evt;
        logic [7:0]  m;
        logic [2:0]  l;
        logic [9:0]  pc;
        logic [7:0]  npc;
    } vec_t;

    vec_t tv[$];

    function automatic logic [21:0] mk(input logic rpt, input logic rel, input logic ext,
                                       input logic [7:0] c, input logic [7:0] m,
                                       input logic [2:0] l);
        return {rpt, rel, ext, c, m, l};
    endfunction

    task automatic add(input logic [7:0] b, input logic ev, input logic [21:0] evt,
                       input logic [7:0] m, input logic [2:0] l, input logic [9:0] pc,
                       input logic [7:0] npc);
        vec_t v;
        v.b = b; v.ev = ev; v.evt = evt; v.m = m; v.l = l; v.pc = pc; v.npc = npc;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge mainclk);
        code = b;
        code_valid = 1'b1;
        @(negedge mainclk);
        code_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [21:0] exp);
        chk({name, "_valid"}, 32'(evt_valid), 32'h1);
        chk({name, "_data"}, 32'(evt_data), 32'(exp));
        evt_ready = 1'b1;
        @(negedge mainclk);
        evt_ready = 1'b0;
    endtask

    initial begin
        // Sequences: make/break, modifiers incl. extended, caps toggling and repeat,
        // dropped housekeeping bytes, num lock, extended 58 that must not toggle caps.
        add(8'h1C, 1, mk(0,0,0,8'h1C,8'h00,3'd0), 8'h00, 3'd0, 10'd1, 8'd1);
        add(8'hF0, 0, '0,                         8'h00, 3'd0, 10'd1, 8'd1);
        add(8'h1C, 1, mk(0,1,0,8'h1C,8'h00,3'd0), 8'h00, 3'd0, 10'd0, 8'd1);
        add(8'h12, 1, mk(0,0,0,8'h12,8'h01,3'd0), 8'h01, 3'd0, 10'd1, 8'd2);
        add(8'h1C, 1, mk(0,0,0,8'h1C,8'h01,3'd0), 8'h01, 3'd0, 10'd2, 8'd3);
        add(8'hE0, 0, '0,                         8'h01, 3'd0, 10'd2, 8'd3);
        add(8'h14, 1, mk(0,0,1,8'h14,8'h09,3'd0), 8'h09, 3'd0, 10'd3, 8'd4);
        add(8'hE0, 0, '0,                         8'h09, 3'd0, 10'd3, 8'd4);
        add(8'hF0, 0, '0,                         8'h09, 3'd0, 10'd3, 8'd4);
        add(8'h14, 1, mk(0,1,1,8'h14,8'h01,3'd0), 8'h01, 3'd0, 10'd2, 8'd4);
        add(8'h1C, 1, mk(1,0,0,8'h1C,8'h01,3'd0), 8'h01, 3'd0, 10'd2, 8'd4);
        add(8'h58, 1, mk(0,0,0,8'h58,8'h01,3'd1), 8'h01, 3'd1, 10'd3, 8'd5);
        add(8'hF0, 0, '0,                         8'h01, 3'd1, 10'd3, 8'd5);
        add(8'h58, 1, mk(0,1,0,8'h58,8'h01,3'd1), 8'h01, 3'd1, 10'd2, 8'd5);
        add(8'h58, 1, mk(0,0,0,8'h58,8'h01,3'd0), 8'h01, 3'd0, 10'd3, 8'd6);
        add(8'h58, 1, mk(1,0,0,8'h58,8'h01,3'd0), 8'h01, 3'd0, 10'd3, 8'd6);
        add(8'hFA, 0, '0,                         8'h01, 3'd0, 10'd3, 8'd6);
        add(8'h00, 0, '0,                         8'h01, 3'd0, 10'd3, 8'd6);
        add(8'h77, 1, mk(0,0,0,8'h77,8'h01,3'd2), 8'h01, 3'd2, 10'd4, 8'd7);
        add(8'hE0, 0, '0,                         8'h01, 3'd2, 10'd4, 8'd7);
        add(8'h58, 1, mk(0,0,1,8'h58,8'h01,3'd2), 8'h01, 3'd2, 10'd5, 8'd8);

        repeat (3) @(negedge mainclk);
        reset = 1'b0;
        @(negedge mainclk);
        mon_en = 1'b1;

        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_data", 32'(evt_data), 32'h0);
        chk("rst_mods", 32'(mods), 32'h0);
        chk("rst_locks", 32'(locks), 32'h0);
        chk("rst_led", 32'(led_update), 32'h0);
        chk("rst_pcnt", 32'(pressed_cnt), 32'h0);
        chk("rst_npc", 32'(new_press_cnt), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            send(tv[i].b);
            if (tv[i].ev) pop_chk($sformatf("v%0d_evt", i), tv[i].evt);
            else chk($sformatf("v%0d_noevt", i), 32'(evt_valid), 32'h0);
            chk($sformatf("v%0d_mods", i), 32'(mods), 32'(tv[i].m));
            chk($sformatf("v%0d_locks", i), 32'(locks), 32'(tv[i].l));
            chk($sformatf("v%0d_pcnt", i), 32'(pressed_cnt), 32'(tv[i].pc));
            chk($sformatf("v%0d_npc", i), 32'(new_press_cnt), 32'(tv[i].npc));
        end
        chk("led_pulses", 32'(led_cnt), 32'd3);

        // Self-test completion while keys held
        send(8'hAA);
        chk("bat_noevt", 32'(evt_valid), 32'h0);
        chk("bat_pcnt", 32'(pressed_cnt), 32'h0);
        chk("bat_mods", 32'(mods), 32'h0);
        chk("bat_locks", 32'(locks), 32'h2);
        chk("bat_led", 32'(led_cnt), 32'd3);

        // Overflow: DEPTH+2 new makes with no consumer
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'h20 + 8'(i));
            if (i == DEPTH - 1) chk("ovf_at_full", 32'(overflow), 32'h0);
        end
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_pcnt", 32'(pressed_cnt), 32'd10);
        chk("ovf_npc", 32'(new_press_cnt), 32'd18);
        @(negedge mainclk);
        clr_ovf = 1'b1;
        @(negedge mainclk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH; i++)
            pop_chk($sformatf("drain%0d", i), mk(0,0,0,8'h20 + 8'(i),8'h00,3'd2));
        chk("drain_empty", 32'(evt_valid), 32'h0);

        // Full FIFO accepts a push when the head is popped in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            send(8'hF0);
            send(8'h20 + 8'(i));
        end
        chk("full_ovf0", 32'(overflow), 32'h0);
        send(8'hF0);
        @(negedge mainclk);
        code = 8'h28;
        code_valid = 1'b1;
        evt_ready = 1'b1;
        @(negedge mainclk);
        code_valid = 1'b0;
        evt_ready = 1'b0;
        chk("pp_ovf", 32'(overflow), 32'h0);
        chk("pp_pcnt", 32'(pressed_cnt), 32'd1);
        for (int i = 1; i <= DEPTH; i++)
            pop_chk($sformatf("pp%0d", i), mk(0,1,0,8'h20 + 8'(i),8'h00,3'd2));
        chk("pp_empty", 32'(evt_valid), 32'h0);

        // Reset in the middle of an E0 prefix
        send(8'hE0);
        @(negedge mainclk);
        reset = 1'b1;
        @(negedge mainclk);
        reset = 1'b0;
        chk("rst2_valid", 32'(evt_valid), 32'h0);
        chk("rst2_locks", 32'(locks), 32'h0);
        chk("rst2_pcnt", 32'(pressed_cnt), 32'h0);
        chk("rst2_npc", 32'(new_press_cnt), 32'h0);
        send(8'h1C);
        pop_chk("rst2_evt", mk(0,0,0,8'h1C,8'h00,3'd0));

        // F0 F0 is a protocol error; the next byte is parsed from idle
        send(8'hF0);
        send(8'hF0);
        chk("f0f0_noevt", 32'(evt_valid), 32'h0);
        send(8'h2D);
        pop_chk("f0f0_next", mk(0,0,0,8'h2D,8'h00,3'd0));
        chk("f0f0_pcnt", 32'(pressed_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
